axi4l_master: RTL and testbench
===============================

# axi4l_master

Single-outstanding AXI4-lite initiator that converts a simple valid/ready command stream into AXI4-lite write or read transactions and returns one response per command. It is the initiator-side counterpart of the `axi4l_write`/`axi4l_read` agents. It drives one write agent and one read agent of the multi-port RAM top, either for traffic generation in benches or for an on-chip controller. It runs on a single clock domain; any clock-domain crossing stays inside the responder agents.

## Interface
Parameters:
- `ADDR_WIDTH`, 3: address width in bits.
- `DATA_WIDTH`, 8: data width in bits; must be a multiple of 8.
- `PROT`, 2'b00: constant value driven on `awprot`/`arprot`.
- `ERR_WIDTH`, 8: width of the error counter.

Ports:
- Clock and reset
  - `aclk` in 1: clock; one clock; all logic rises on `aclk`.
  - `aresetn` in 1: reset, asynchronous and active-low.
- Command interface
  - `cmd_valid` in 1: command present.
  - `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
  - `cmd_wr` in 1: 1 = write, 0 = read.
  - `cmd_addr` in ADDR_WIDTH: target address.
  - `cmd_wdata` in DATA_WIDTH: write data; ignored for reads.
  - `cmd_wstrb` in DATA_WIDTH/8: write strobes; ignored for reads.
- Response interface
  - `rsp_valid` out 1: response present.
  - `rsp_ready` in 1: response consumed.
  - `rsp_rdata` out DATA_WIDTH: read data; 0 for writes.
  - `rsp_resp` out 2: captured `bresp`/`rresp`.
- Error counter
  - `err_count` out ERR_WIDTH: saturating count of non-OKAY responses.
- AXI4-lite write channels
  - `awvalid` out 1, `awready` in 1, `awaddr` out ADDR_WIDTH, `awprot` out 2.
  - `wvalid` out 1, `wready` in 1, `wdata` out DATA_WIDTH, `wstrb` out DATA_WIDTH/8.
  - `bvalid` in 1, `bready` out 1, `bresp` in 2.
- AXI4-lite read channels
  - `arvalid` out 1, `arready` in 1, `araddr` out ADDR_WIDTH, `arprot` out 2.
  - `rvalid` in 1, `rready` out 1, `rdata` in DATA_WIDTH, `rresp` in 2.

## Operation
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch addr/data/strb into holding registers.
  - Go to WR_REQ if `cmd_wr`=1, else RD_REQ.
- WR_REQ:
  - `awvalid` and `wvalid` are both set on entry.
  - Each drops the cycle after its own handshake (`awvalid&awready`, `wvalid&wready`); the two handshakes are independent and may occur in either order or the same cycle.
  - Two internal done flags record each handshake.
  - When both are done, go to WR_RSP.
- WR_RSP:
  - `bready`=1.
  - On `bvalid`, capture `bresp` into `rsp_resp`, set `rsp_rdata`=0, go to RSP.
- RD_REQ:
  - `arvalid`=1 until `arready`, then go to RD_RSP.
- RD_RSP:
  - `rready`=1.
  - On `rvalid`, capture `rdata`/`rresp`, go to RSP.
- RSP:
  - `rsp_valid`=1 until `rsp_ready`, then go to IDLE.
- Payload stability: `awaddr`, `wdata`, `wstrb` and `araddr` come from the holding registers and stay stable while the matching valid is high. `awprot`=`arprot`=PROT always.
- Valid signals: no valid is ever withdrawn before its handshake.
- Error counter: `err_count` increments by 1 on each captured response with resp≠2'b00, and saturates at 2^ERR_WIDTH-1.
- Unexpected responses: `bvalid`/`rvalid` arriving outside WR_RSP/RD_RSP is not accepted (`bready`/`rready`=0) and has no effect.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational path from any input to any output.
- Reset values:
  - State = IDLE.
  - `cmd_ready`=0 during reset; it rises on the first `aclk` edge after `aresetn` deasserts.
  - All AXI valid/ready outputs = 0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_resp`=0, `err_count`=0.
  - Address/data outputs = 0.
- Write, zero-wait responder:
  - Edge 0: cmd handshake.
  - Cycle 1: `awvalid`/`wvalid` high and both handshakes complete.
  - Cycle 2: `bready` high; `bvalid` accepted.
  - Cycle 3: `rsp_valid` high.
- Read, zero-wait responder:
  - Edge 0: cmd handshake.
  - Cycle 1: `arvalid` high.
  - Cycle 2: `rready` high.
  - Cycle 3: `rsp_valid` high.
- `cmd_ready` returns high the cycle after the `rsp_valid&rsp_ready` handshake. Maximum throughput is one command per 4 cycles.
- Reset mid-transaction: all valids drop immediately (asynchronous reset), the holding registers clear, and the in-flight command is lost with no response. `err_count` clears.

## Test plan
- Reset, then write `cmd_addr`=3, `cmd_wdata`=8'hA5, `cmd_wstrb`=1 against a zero-wait responder with `bresp`=0:
  - `awaddr`=3, `wdata`=A5 seen in cycle 1.
  - `rsp_valid` in cycle 3 with `rsp_resp`=0, `rsp_rdata`=0.
  - `err_count`=0.
- Read addr 3 with the responder returning `rdata`=A5, `rresp`=0:
  - `araddr`=3.
  - `rsp_rdata`=A5, `rsp_resp`=0.
- Write with `awready` delayed 4 cycles and `wready` immediate:
  - `wvalid` drops after cycle 1.
  - `awvalid` is held with stable `awaddr` until accepted.
  - `bready` rises only after both handshakes.
- Read with `rresp`=2'b10, repeated 3 times:
  - `err_count`=3.
  - Forcing counts to 255 (ERR_WIDTH=8) and one more error keeps `err_count`=255.
- `rsp_ready` held low 5 cycles:
  - `rsp_valid` and the payload stay stable.
  - `cmd_ready` stays 0 and a pending `cmd_valid` is not accepted until the cycle after `rsp_ready` rises.
- Assert `aresetn`=0 while `awvalid`=1:
  - All valids are 0 asynchronously and `rsp_valid` never asserts.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/axi4l_master.sv
// Single-outstanding AXI4-lite initiator: one command in, one AXI
// transaction out, one response back, plus a saturating error count.
module axi4l_master #(
    parameter int         ADDR_WIDTH = 3,
    parameter int         DATA_WIDTH = 8,
    parameter logic [1:0] PROT       = 2'b00,
    parameter int         ERR_WIDTH  = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ERR_WIDTH-1:0]    err_count,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [1:0]              awprot,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [1:0]              arprot,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp
);

    localparam int SW = DATA_WIDTH / 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_REQ = 3'd1;
    localparam logic [2:0] WR_RSP = 3'd2;
    localparam logic [2:0] RD_REQ = 3'd3;
    localparam logic [2:0] RD_RSP = 3'd4;
    localparam logic [2:0] RSP    = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic                  aw_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;

    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;
    logic aw_fin;
    logic w_fin;
    logic err_hit;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign ar_hs  = arvalid & arready;
    assign b_hs   = bready & bvalid;
    assign r_hs   = rready & rvalid;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign err_hit = (b_hs && bresp != 2'b00)
                   || (r_hs && rresp != 2'b00);

    assign bready    = (state == WR_RSP);
    assign rready    = (state == RD_RSP);
    assign rsp_valid = (state == RSP);

    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign awprot = PROT;
    assign arprot = PROT;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_hs)
                    state_nx = cmd_wr ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                if (aw_fin && w_fin)
                    state_nx = WR_RSP;
            end
            WR_RSP: begin
                if (bvalid)
                    state_nx = RSP;
            end
            RD_REQ: begin
                if (ar_hs)
                    state_nx = RD_RSP;
            end
            RD_RSP: begin
                if (rvalid)
                    state_nx = RSP;
            end
            RSP: begin
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // cmd_ready is a flop so it stays low through reset and rises
    // on the first edge after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == IDLE);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_hs) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // AW and W complete independently; done flags remember each one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            arvalid <= 1'b0;
        end else begin
            if (cmd_hs && cmd_wr)
                awvalid <= 1'b1;
            else if (aw_hs)
                awvalid <= 1'b0;

            if (cmd_hs && cmd_wr)
                wvalid <= 1'b1;
            else if (w_hs)
                wvalid <= 1'b0;

            if (cmd_hs)
                aw_done <= 1'b0;
            else if (aw_hs)
                aw_done <= 1'b1;

            if (cmd_hs)
                w_done <= 1'b0;
            else if (w_hs)
                w_done <= 1'b1;

            if (cmd_hs && !cmd_wr)
                arvalid <= 1'b1;
            else if (ar_hs)
                arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            err_count <= '0;
        end else begin
            if (b_hs) begin
                rsp_rdata <= '0;
                rsp_resp  <= bresp;
            end else if (r_hs) begin
                rsp_rdata <= rdata;
                rsp_resp  <= rresp;
            end
            if (err_hit && err_count != '1)
                err_count <= err_count + ERR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axi4l_master.sv
// Bench for axi4l_master: scripted commands against a cycle-level
// responder, responses checked against a scoreboard queue.
module tb_axi4l_master;

    typedef struct packed {
        logic [7:0] rdata;
        logic [1:0] resp;
    } exp_t;

    logic       aclk;
    logic       aresetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [0:0] cmd_wstrb;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [7:0] err_count;
    logic       awvalid;
    logic       awready;
    logic [2:0] awaddr;
    logic [1:0] awprot;
    logic       wvalid;
    logic       wready;
    logic [7:0] wdata;
    logic [0:0] wstrb;
    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;
    logic       arvalid;
    logic       arready;
    logic [2:0] araddr;
    logic [1:0] arprot;
    logic       rvalid;
    logic       rready;
    logic [7:0] rdata;
    logic [1:0] rresp;

    int   checks;
    int   failures;
    int   err_exp;
    exp_t sb[$];
    logic [7:0] ref_mem [8];
    logic [7:0] slv_mem [8];

    axi4l_master dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .err_count (err_count),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arprot    (arprot),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic slv_idle();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 8'h00;
    endtask

    // Present a command and return at the negedge of cycle 1.
    task automatic send_cmd(input logic wr, input logic [2:0] addr,
                            input logic [7:0] data, input logic strb);
        int k;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge aclk);
            k++;
        end
        if (!cmd_ready)
            chk("cmd_accept_timeout", 0, 1);
        @(negedge aclk);
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic run_cmd(input logic wr, input logic [2:0] addr,
                           input logic [7:0] data, input logic strb,
                           input int aw_dly, input int w_dly,
                           input logic [1:0] resp, input int hold);
        exp_t       e;
        exp_t       got_e;
        int         exp_cyc;
        int         hcnt;
        bit         aw_ok, w_ok, b_seen, ar_ok, r_seen;
        bit         got, first;
        logic [2:0] aw_cap, ar_cap;
        logic [7:0] w_cap;
        logic       s_cap;
        logic [7:0] keep_d;
        logic [1:0] keep_r;

        send_cmd(wr, addr, data, strb);
        e.resp  = resp;
        e.rdata = wr ? 8'h00 : ref_mem[addr];
        if (wr && strb)
            ref_mem[addr] = data;
        if (resp != 2'b00 && err_exp < 255)
            err_exp++;
        sb.push_back(e);

        exp_cyc = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) : 3;
        {aw_ok, w_ok, b_seen, ar_ok, r_seen, got, first} = '0;
        {aw_cap, ar_cap, w_cap, s_cap, keep_d, keep_r} = '0;
        hcnt = 0;

        for (int n = 1; n <= 60 && !got; n++) begin
            if (wr) begin
                chk("awvalid", awvalid, !aw_ok);
                chk("wvalid", wvalid, !w_ok);
                chk("bready", bready, aw_ok && w_ok && !b_seen);
                if (awvalid)
                    chk("awaddr", awaddr, addr);
                if (wvalid)
                    chk("wdata", {wdata, wstrb}, {data, strb});
                awready = awvalid && (n > aw_dly);
                wready  = wvalid && (n > w_dly);
                bvalid  = bready;
                bresp   = resp;
                if (awvalid && awready) begin
                    aw_ok  = 1'b1;
                    aw_cap = awaddr;
                end
                if (wvalid && wready) begin
                    w_ok  = 1'b1;
                    w_cap = wdata;
                    s_cap = wstrb[0];
                end
                if (bready && bvalid) begin
                    b_seen = 1'b1;
                    if (s_cap)
                        slv_mem[aw_cap] = w_cap;
                end
            end else begin
                chk("arvalid", arvalid, !ar_ok);
                chk("rready", rready, ar_ok && !r_seen);
                if (arvalid)
                    chk("araddr", araddr, addr);
                arready = arvalid;
                rvalid  = rready;
                rresp   = resp;
                rdata   = rready ? slv_mem[ar_cap] : 8'h00;
                if (arvalid && arready) begin
                    ar_ok  = 1'b1;
                    ar_cap = araddr;
                end
                if (rready && rvalid)
                    r_seen = 1'b1;
            end

            if (rsp_valid) begin
                if (!first) begin
                    first  = 1'b1;
                    keep_d = rsp_rdata;
                    keep_r = rsp_resp;
                    chk("rsp_cycle", n, exp_cyc);
                end
                chk("rsp_stable", {rsp_rdata, rsp_resp}, {keep_d, keep_r});
                chk("cmd_ready_rsp", cmd_ready, 0);
                if (hcnt < hold) begin
                    rsp_ready = 1'b0;
                    cmd_valid = 1'b1;
                    cmd_wr    = 1'b0;
                    hcnt++;
                end else begin
                    rsp_ready = 1'b1;
                    got = 1'b1;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 0, 1);
                    end else begin
                        got_e = sb.pop_front();
                        chk("rsp_rdata", rsp_rdata, got_e.rdata);
                        chk("rsp_resp", rsp_resp, got_e.resp);
                    end
                    chk("err_count", err_count, err_exp);
                end
            end
            @(negedge aclk);
        end

        slv_idle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        if (!got)
            chk("rsp_timeout", 0, 1);
        chk("rsp_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        err_exp   = 0;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        bresp     = 2'b00;
        rresp     = 2'b00;
        slv_idle();
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 8'h00;
            slv_mem[i] = 8'h00;
        end

        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids",
            {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp}, 0);
        chk("rst_err", err_count, 0);
        chk("rst_payload", {awaddr, araddr, wdata, wstrb}, 0);
        chk("prot", {awprot, arprot}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("cmd_ready_up", cmd_ready, 1);

        run_cmd(1'b1, 3'd3, 8'hA5, 1'b1, 0, 0, 2'b00, 0);
        run_cmd(1'b0, 3'd3, 8'h00, 1'b0, 0, 0, 2'b00, 0);
        run_cmd(1'b1, 3'd2, 8'h77, 1'b1, 4, 0, 2'b00, 0);
        run_cmd(1'b1, 3'd6, 8'h5A, 1'b1, 0, 3, 2'b00, 0);
        run_cmd(1'b1, 3'd3, 8'hFF, 1'b0, 1, 1, 2'b00, 0);
        run_cmd(1'b0, 3'd3, 8'h00, 1'b0, 0, 0, 2'b00, 0);
        run_cmd(1'b0, 3'd2, 8'h00, 1'b0, 0, 0, 2'b00, 0);
        run_cmd(1'b1, 3'd7, 8'hC3, 1'b1, 2, 2, 2'b11, 0);
        chk("err_after_wr_err", err_count, 1);
        run_cmd(1'b0, 3'd6, 8'h00, 1'b0, 0, 0, 2'b00, 5);

        for (int i = 0; i < 3; i++)
            run_cmd(1'b0, 3'd7, 8'h00, 1'b0, 0, 0, 2'b10, 0);
        chk("err_four", err_count, 4);

        while (err_exp < 255)
            run_cmd(1'b0, 3'($urandom_range(0, 7)), 8'h00, 1'b0,
                    0, 0, 2'b10, 0);
        chk("err_255", err_count, 255);
        run_cmd(1'b0, 3'd1, 8'h00, 1'b0, 0, 0, 2'b10, 0);
        chk("err_sat", err_count, 255);

        send_cmd(1'b1, 3'd5, 8'h3C, 1'b1);
        chk("mid_awvalid", awvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_valids",
            {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        chk("mid_cmd_ready", cmd_ready, 0);
        chk("mid_err", err_count, 0);
        chk("mid_payload", {awaddr, wdata, wstrb}, 0);
        err_exp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("mid_no_rsp", rsp_valid, 0);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_cmd_ready_up", cmd_ready, 1);
        chk("mid_no_rsp_after", rsp_valid, 0);
        run_cmd(1'b0, 3'd3, 8'h00, 1'b0, 0, 0, 2'b00, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
